// File: rtl/alu_status_pkg.sv
// Shared constants for the ALU status stage: widths, flag-op codes, P bit positions.
package alu_status_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned FOP_W  = 4;

   localparam logic [FOP_W-1:0] FOP_NOP  = 4'd0;
   localparam logic [FOP_W-1:0] FOP_NZ   = 4'd1;
   localparam logic [FOP_W-1:0] FOP_NZC  = 4'd2;
   localparam logic [FOP_W-1:0] FOP_NZCV = 4'd3;
   localparam logic [FOP_W-1:0] FOP_BIT  = 4'd4;
   localparam logic [FOP_W-1:0] FOP_PLP  = 4'd5;
   localparam logic [FOP_W-1:0] FOP_CLC  = 4'd6;
   localparam logic [FOP_W-1:0] FOP_SEC  = 4'd7;
   localparam logic [FOP_W-1:0] FOP_CLI  = 4'd8;
   localparam logic [FOP_W-1:0] FOP_SEI  = 4'd9;
   localparam logic [FOP_W-1:0] FOP_CLD  = 4'd10;
   localparam logic [FOP_W-1:0] FOP_SED  = 4'd11;
   localparam logic [FOP_W-1:0] FOP_CLV  = 4'd12;

   localparam int unsigned P_C = 0;
   localparam int unsigned P_Z = 1;
   localparam int unsigned P_I = 2;
   localparam int unsigned P_D = 3;
   localparam int unsigned P_B = 4;
   localparam int unsigned P_U = 5;
   localparam int unsigned P_V = 6;
   localparam int unsigned P_N = 7;

endpackage

// File: rtl/alu_status_if.sv
// Bus between the ALU/decoder side and the status stage; master drives, slave is the stage.
interface alu_status_if;
   import alu_status_pkg::*;

   logic              RDY;
   logic [DATA_W-1:0] alu_out;
   logic              alu_co;
   logic              alu_v;
   logic              alu_n;
   logic              alu_hc;
   logic              adj_en;
   logic              adj_sub;
   logic [FOP_W-1:0]  flag_op;
   logic [DATA_W-1:0] di;
   logic              brk;
   logic [DATA_W-1:0] res;
   logic [DATA_W-1:0] p;
   logic              flag_c;
   logic              flag_z;
   logic              flag_n;
   logic              flag_v;
   logic              flag_d;
   logic              flag_i;

   modport master (
      output RDY, alu_out, alu_co, alu_v, alu_n, alu_hc, adj_en, adj_sub, flag_op, di, brk,
      input  res, p, flag_c, flag_z, flag_n, flag_v, flag_d, flag_i
   );

   modport slave (
      input  RDY, alu_out, alu_co, alu_v, alu_n, alu_hc, adj_en, adj_sub, flag_op, di, brk,
      output res, p, flag_c, flag_z, flag_n, flag_v, flag_d, flag_i
   );

endinterface

// File: rtl/alu_status_decimal_adjust.sv
// BCD decimal-adjust of an ALU result; nibble-wise, each nibble wraps mod 16 independently.
module decimal_adjust
   import alu_status_pkg::*;
(
   input  logic [DATA_W-1:0] in_i,
   input  logic              hc_i,
   input  logic              co_i,
   input  logic              sub_i,
   input  logic              en_i,
   output logic [DATA_W-1:0] out_o
);

   logic [3:0] lo_add;
   logic [3:0] hi_add;

   // Select per-nibble correction: +6 on carry for ADC, +0xA (i.e. -6) on no-carry for SBC.
   always_comb begin
      lo_add = 4'h0;
      hi_add = 4'h0;
      if (en_i) begin
         if (sub_i) begin
            if (!hc_i) lo_add = 4'hA;
            if (!co_i) hi_add = 4'hA;
         end else begin
            if (hc_i) lo_add = 4'h6;
            if (co_i) hi_add = 4'h6;
         end
      end
   end

   // Nibble sums are 4 bits wide, so no carry crosses from low to high nibble.
   always_comb begin
      out_o = {4'(in_i[7:4] + hi_add), 4'(in_i[3:0] + lo_add)};
   end

endmodule

// File: rtl/alu_status.sv
// 6502 status stage: registers the decimal-adjusted ALU result and owns the P register.
module alu_status
   import alu_status_pkg::*;
#(
   parameter bit RESET_I = 1'b1,
   parameter bit RESET_D = 1'b0
)(
   input logic         clk,
   input logic         reset,
   alu_status_if.slave bus
);

   logic [DATA_W-1:0] adj;
   logic [DATA_W-1:0] res_q, res_d;
   logic              n_q, n_d;
   logic              v_q, v_d;
   logic              d_q, d_d;
   logic              i_q, i_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic              n_src;
   logic              z_src;
   logic [DATA_W-1:0] p_c;
   logic              unused_di;

   decimal_adjust u_adj (
      .in_i  (bus.alu_out),
      .hc_i  (bus.alu_hc),
      .co_i  (bus.alu_co),
      .sub_i (bus.adj_sub),
      .en_i  (bus.adj_en),
      .out_o (adj)
   );

   // PLP drops the B and unused bits of the pulled byte.
   assign unused_di = ^bus.di[5:4];

   // N/Z follow the adjusted value in decimal mode, else the raw ALU result.
   always_comb begin
      n_src = bus.adj_en ? adj[7] : bus.alu_n;
      z_src = bus.adj_en ? (adj == '0) : (bus.alu_out == '0);
   end

   // Next-state for result and flags; flags not named by the op hold.
   always_comb begin
      res_d = adj;
      n_d   = n_q;
      v_d   = v_q;
      d_d   = d_q;
      i_d   = i_q;
      z_d   = z_q;
      c_d   = c_q;
      case (bus.flag_op)
         FOP_NZ: begin
            n_d = n_src;
            z_d = z_src;
         end
         FOP_NZC: begin
            n_d = n_src;
            z_d = z_src;
            c_d = bus.alu_co;
         end
         FOP_NZCV: begin
            n_d = n_src;
            z_d = z_src;
            c_d = bus.alu_co;
            v_d = bus.alu_v;
         end
         FOP_BIT: begin
            n_d = bus.di[7];
            v_d = bus.di[6];
            z_d = (bus.alu_out == '0);
         end
         FOP_PLP: begin
            n_d = bus.di[P_N];
            v_d = bus.di[P_V];
            d_d = bus.di[P_D];
            i_d = bus.di[P_I];
            z_d = bus.di[P_Z];
            c_d = bus.di[P_C];
         end
         FOP_CLC: c_d = 1'b0;
         FOP_SEC: c_d = 1'b1;
         FOP_CLI: i_d = 1'b0;
         FOP_SEI: i_d = 1'b1;
         FOP_CLD: d_d = 1'b0;
         FOP_SED: d_d = 1'b1;
         FOP_CLV: v_d = 1'b0;
         default: ;
      endcase
   end

   // State registers; RDY low freezes everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q <= '0;
         n_q   <= 1'b0;
         v_q   <= 1'b0;
         d_q   <= RESET_D;
         i_q   <= RESET_I;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
      end else if (bus.RDY) begin
         res_q <= res_d;
         n_q   <= n_d;
         v_q   <= v_d;
         d_q   <= d_d;
         i_q   <= i_d;
         z_q   <= z_d;
         c_q   <= c_d;
      end
   end

   // P image for pushes: registered flags, live B, bit 5 tied high.
   always_comb begin
      p_c      = '0;
      p_c[P_N] = n_q;
      p_c[P_V] = v_q;
      p_c[P_U] = 1'b1;
      p_c[P_B] = bus.brk;
      p_c[P_D] = d_q;
      p_c[P_I] = i_q;
      p_c[P_Z] = z_q;
      p_c[P_C] = c_q;
   end

   assign bus.res    = res_q;
   assign bus.p      = p_c;
   assign bus.flag_n = n_q;
   assign bus.flag_v = v_q;
   assign bus.flag_d = d_q;
   assign bus.flag_i = i_q;
   assign bus.flag_z = z_q;
   assign bus.flag_c = c_q;

endmodule

// File: tb/tb_alu_status.sv
// Directed bench for alu_status: vector table plus stall, BIT/explicit-op and async reset sequences.
module tb_alu_status;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   alu_status_if bus();

   alu_status dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] alu_out;
      logic       co;
      logic       v;
      logic       n;
      logic       hc;
      logic       adj_en;
      logic       adj_sub;
      logic [3:0] flag_op;
      logic       brk;
      logic [7:0] exp_res;
      logic [7:0] exp_p;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string name, input logic [7:0] exp_p);
      logic [7:0] act;
      logic [7:0] exp;
      act = {2'b00, bus.flag_n, bus.flag_v, bus.flag_d, bus.flag_i, bus.flag_z, bus.flag_c};
      exp = {2'b00, exp_p[7], exp_p[6], exp_p[3], exp_p[2], exp_p[1], exp_p[0]};
      chk(name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] ao, input logic co, input logic v, input logic n,
                        input logic hc, input logic en, input logic sub, input logic [3:0] op,
                        input logic [7:0] di, input logic brk);
      bus.alu_out = ao;
      bus.alu_co  = co;
      bus.alu_v   = v;
      bus.alu_n   = n;
      bus.alu_hc  = hc;
      bus.adj_en  = en;
      bus.adj_sub = sub;
      bus.flag_op = op;
      bus.di      = di;
      bus.brk     = brk;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      //         alu_out co v  n  hc en sub op     brk res    p
      vecs[0]  = '{8'h1A, 0, 0, 0, 1, 1, 0, 4'd2,  0, 8'h10, 8'h24}; // BCD 09+01
      vecs[1]  = '{8'hAA, 1, 0, 0, 1, 1, 0, 4'd2,  0, 8'h00, 8'h27}; // BCD 99+01
      vecs[2]  = '{8'h0F, 1, 0, 0, 0, 1, 1, 4'd2,  0, 8'h09, 8'h25}; // BCD 10-01
      vecs[3]  = '{8'h80, 0, 1, 1, 0, 0, 0, 4'd3,  0, 8'h80, 8'hE4}; // binary NZCV
      vecs[4]  = '{8'h00, 1, 0, 0, 0, 0, 0, 4'd1,  0, 8'h00, 8'h66}; // NZ only, C/V hold
      vecs[5]  = '{8'h7A, 1, 0, 0, 1, 1, 0, 4'd2,  0, 8'hD0, 8'hE5}; // N from adj, not alu_n
      vecs[6]  = '{8'h33, 0, 0, 0, 0, 0, 0, 4'd0,  1, 8'h33, 8'hF5}; // NOP, live brk
      vecs[7]  = '{8'h01, 0, 0, 0, 0, 0, 0, 4'd11, 0, 8'h01, 8'hED}; // SED
      vecs[8]  = '{8'h01, 0, 0, 0, 0, 0, 0, 4'd10, 0, 8'h01, 8'hE5}; // CLD
      vecs[9]  = '{8'h01, 0, 0, 0, 0, 0, 0, 4'd8,  0, 8'h01, 8'hE1}; // CLI
      vecs[10] = '{8'h01, 0, 0, 0, 0, 0, 0, 4'd9,  0, 8'h01, 8'hE5}; // SEI
      vecs[11] = '{8'h01, 0, 0, 0, 0, 0, 0, 4'd6,  0, 8'h01, 8'hE4}; // CLC
      vecs[12] = '{8'hFF, 0, 0, 0, 0, 1, 1, 4'd3,  0, 8'h99, 8'hA4}; // BCD 00-01 borrow both
      vecs[13] = '{8'h42, 0, 0, 0, 0, 1, 0, 4'd1,  0, 8'h42, 8'h24}; // decimal, no correction
      vecs[14] = '{8'h1A, 1, 0, 0, 1, 0, 0, 4'd0,  0, 8'h1A, 8'h24}; // adj_en=0 passes raw

      reset   = 1'b1;
      bus.RDY = 1'b1;
      drive(8'h00, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);
      #3;
      chk("reset_res", bus.res, 8'h00);
      chk("reset_p", bus.p, 8'h24);
      chk_flags("reset_flags", 8'h24);
      reset = 1'b0;

      // Vector table
      for (int k = 0; k < NV; k++) begin
         drive(vecs[k].alu_out, vecs[k].co, vecs[k].v, vecs[k].n, vecs[k].hc,
               vecs[k].adj_en, vecs[k].adj_sub, vecs[k].flag_op, 8'h00, vecs[k].brk);
         tick();
         chk($sformatf("vec%0d_res", k), bus.res, vecs[k].exp_res);
         chk($sformatf("vec%0d_p", k), bus.p, vecs[k].exp_p);
         chk_flags($sformatf("vec%0d_flags", k), vecs[k].exp_p);
      end

      // PLP under stall: nothing moves while RDY is low
      drive(8'h55, 1, 1, 1, 1, 0, 0, 4'd5, 8'hFF, 0);
      bus.RDY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stall%0d_p", k), bus.p, 8'h24);
         chk($sformatf("stall%0d_res", k), bus.res, 8'h1A);
      end
      bus.RDY = 1'b1;
      tick();
      chk("plp_p", bus.p, 8'hEF);
      chk("plp_res", bus.res, 8'h55);
      chk_flags("plp_flags", 8'hEF);

      // BIT then explicit flag ops
      drive(8'h00, 0, 0, 1, 0, 0, 0, 4'd4, 8'h40, 0);
      tick();
      chk("bit_p", bus.p, 8'h6F);
      drive(8'h00, 0, 0, 0, 0, 0, 0, 4'd12, 8'h00, 0);
      tick();
      chk("clv_p", bus.p, 8'h2F);
      drive(8'h00, 0, 0, 0, 0, 0, 0, 4'd6, 8'h00, 0);
      tick();
      chk("clc_p", bus.p, 8'h2E);
      drive(8'h80, 0, 1, 1, 0, 0, 0, 4'd7, 8'h00, 0);
      tick();
      chk("sec_p", bus.p, 8'h2F);
      drive(8'h80, 0, 1, 1, 0, 0, 0, 4'd14, 8'hC0, 0);
      tick();
      chk("rsvd_p", bus.p, 8'h2F);
      chk("rsvd_res", bus.res, 8'h80);

      // Async reset mid-cycle from P all ones
      drive(8'h55, 1, 1, 1, 1, 0, 0, 4'd5, 8'hFF, 0);
      tick();
      chk("pre_reset_p", bus.p, 8'hEF);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_res", bus.res, 8'h00);
      chk("async_reset_p", bus.p, 8'h24);
      chk_flags("async_reset_flags", 8'h24);
      tick();
      chk("reset_hold_p", bus.p, 8'h24);
      #2;
      reset = 1'b0;
      tick();
      chk("post_reset_p", bus.p, 8'hEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
